// File: rtl/seven_segment_mux_if.sv
// Bus between the BCD source and the multiplexed 7-segment driver.
//   master : load, bcd, dp_in, blank_lz out; segments, dp, digit_en, frame_done in
//   slave  : the reverse (used by seven_segment_mux)
//   load       capture bcd/dp_in this cycle
//   bcd        digit i on bits [4i+3:4i], digit 0 least significant
//   dp_in      decimal point per digit
//   blank_lz   leading-zero blanking enable (sampled live)
//   segments   bit0=a .. bit6=g
//   dp         decimal point of the active digit
//   digit_en   one-hot digit select
//   frame_done one-clock pulse per completed frame
interface seven_segment_mux_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     dp_in;
   logic                  blank_lz;
   logic [6:0]            segments;
   logic                  dp;
   logic [DIGITS-1:0]     digit_en;
   logic                  frame_done;

   modport master (
      output load, bcd, dp_in, blank_lz,
      input  segments, dp, digit_en, frame_done
   );

   modport slave (
      input  load, bcd, dp_in, blank_lz,
      output segments, dp, digit_en, frame_done
   );
endinterface

// File: rtl/seven_segment_mux.sv
// Time-multiplexed driver for DIGITS BCD digits on one shared 7-segment bus.
// Frame-aligned double-buffered updates, leading-zero blanking, per-digit
// decimal points, dark time at the start of each slot, selectable polarity.
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    seven_segment_mux_if slave modport (see interface for signals)
module seven_segment_mux #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned DIV            = 4,
   parameter int unsigned BLANK_CYCLES   = 1,
   parameter bit          ACTIVE_LOW_SEG = 1'b0,
   parameter bit          ACTIVE_LOW_DIG = 1'b0
) (
   input logic                clk,
   input logic                reset,
   seven_segment_mux_if.slave bus
);
   localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned SlotW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [SlotW-1:0]      slot_q;
   logic [IdxW-1:0]       idx_q;
   logic [4*DIGITS-1:0]   display_q;
   logic [DIGITS-1:0]     display_dp_q;
   logic [4*DIGITS-1:0]   pending_bcd_q;
   logic [DIGITS-1:0]     pending_dp_q;
   logic                  pending_q;

   logic slot_last, idx_last, fb, slot_dark;

   assign slot_last = (slot_q == SlotW'(DIV - 1));
   assign idx_last  = (idx_q == IdxW'(DIGITS - 1));
   assign fb        = slot_last & idx_last;
   assign slot_dark = (slot_q < SlotW'(BLANK_CYCLES));

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // zero_run[i] is set when digits i..DIGITS-1 of the display are all zero.
   logic [DIGITS:0]   zero_run;
   logic [3:0]        cur_nib;
   logic              cur_dp;
   logic              cur_blank;
   logic [6:0]        seg_d;
   logic              dp_d;
   logic [DIGITS-1:0] en_d;

   always_comb begin
      zero_run         = '0;
      zero_run[DIGITS] = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run[i] = zero_run[i+1] & (display_q[4*i +: 4] == 4'd0);
      end
      cur_nib   = 4'd0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IdxW'(i)) begin
            cur_nib   = display_q[4*i +: 4];
            cur_dp    = display_dp_q[i];
            // Digit 0 always shows, so a zero value still reads "0".
            cur_blank = (i != 0) && bus.blank_lz && zero_run[i];
         end
      end
      if (slot_dark) begin
         seg_d = 7'h00;
         dp_d  = 1'b0;
         en_d  = '0;
      end else begin
         seg_d = cur_blank ? 7'h00 : decode(cur_nib);
         dp_d  = cur_dp;
         en_d  = DIGITS'(1) << idx_q;
      end
   end

   // Counters and double buffer. The visible display only changes on the
   // frame boundary, so a frame never mixes old and new digits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q        <= '0;
         idx_q         <= '0;
         display_q     <= '0;
         display_dp_q  <= '0;
         pending_bcd_q <= '0;
         pending_dp_q  <= '0;
         pending_q     <= 1'b0;
      end else begin
         if (slot_last) begin
            slot_q <= '0;
            idx_q  <= idx_last ? '0 : idx_q + IdxW'(1);
         end else begin
            slot_q <= slot_q + SlotW'(1);
         end

         if (fb) begin
            if (bus.load) begin
               display_q    <= bus.bcd;
               display_dp_q <= bus.dp_in;
            end else if (pending_q) begin
               display_q    <= pending_bcd_q;
               display_dp_q <= pending_dp_q;
            end
            pending_q <= 1'b0;
         end else if (bus.load) begin
            pending_bcd_q <= bus.bcd;
            pending_dp_q  <= bus.dp_in;
            pending_q     <= 1'b1;
         end
      end
   end

   // Polarity is folded into the output flops so the pins never glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.segments   <= {7{ACTIVE_LOW_SEG}};
         bus.dp         <= ACTIVE_LOW_SEG;
         bus.digit_en   <= {DIGITS{ACTIVE_LOW_DIG}};
         bus.frame_done <= 1'b0;
      end else begin
         bus.segments   <= seg_d ^ {7{ACTIVE_LOW_SEG}};
         bus.dp         <= dp_d ^ ACTIVE_LOW_SEG;
         bus.digit_en   <= en_d ^ {DIGITS{ACTIVE_LOW_DIG}};
         bus.frame_done <= fb;
      end
   end
endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: one active-high instance and one inverted
// instance, checked cycle by cycle through an expectation queue.
module tb_seven_segment_mux;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   seven_segment_mux_if #(.DIGITS(4)) bus1 ();
   seven_segment_mux_if #(.DIGITS(4)) bus2 ();

   seven_segment_mux #(
      .DIGITS(4), .DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_DIG(1'b0)
   ) u_dut (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   seven_segment_mux #(
      .DIGITS(4), .DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_DIG(1'b1)
   ) u_dut_inv (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   typedef struct packed {
      int         id;
      logic [3:0] en;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      logic [3:0] en2;
      logic [6:0] seg2;
      logic       dp2;
   } exp_t;

   exp_t       exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         k;
   logic [6:0] cur_seg[4], nxt_seg[4], cur_seg2[4], nxt_seg2[4];
   logic [3:0] cur_dp, nxt_dp;
   logic       pend;
   int         pend_s;

   // Monitor: compares whatever is expected for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if ({bus1.digit_en, bus1.segments, bus1.dp, bus1.frame_done} !==
             {e.en, e.seg, e.dp, e.fd}) begin
            n_bad++;
            $display("FAIL normal edge=%0d got en=%b seg=%h dp=%b fd=%b want en=%b seg=%h dp=%b fd=%b",
                     e.id, bus1.digit_en, bus1.segments, bus1.dp, bus1.frame_done,
                     e.en, e.seg, e.dp, e.fd);
         end
         n_cmp++;
         if ({bus2.digit_en, bus2.segments, bus2.dp, bus2.frame_done} !==
             {e.en2, e.seg2, e.dp2, e.fd}) begin
            n_bad++;
            $display("FAIL inverted edge=%0d got en=%b seg=%h dp=%b fd=%b want en=%b seg=%h dp=%b fd=%b",
                     e.id, bus2.digit_en, bus2.segments, bus2.dp, bus2.frame_done,
                     e.en2, e.seg2, e.dp2, e.fd);
         end
      end
   end

   task automatic push_reset();
      exp_t e;
      e.id   = -1;
      e.en   = 4'h0;
      e.seg  = 7'h00;
      e.dp   = 1'b0;
      e.fd   = 1'b0;
      e.en2  = 4'hF;
      e.seg2 = 7'h7F;
      e.dp2  = 1'b1;
      exp_q.push_back(e);
   endtask

   // Expected outputs after edge k, which reflect the counter state k-1.
   task automatic push_edge();
      exp_t e;
      int   s, slot, dig;
      s    = k - 1;
      slot = s % 4;
      dig  = (s / 4) % 4;
      if ((s % 16 == 0) && pend && (pend_s < s)) begin
         cur_seg  = nxt_seg;
         cur_dp   = nxt_dp;
         cur_seg2 = nxt_seg2;
         pend     = 1'b0;
      end
      e.id = k;
      e.fd = (s % 16 == 15);
      if (slot < 1) begin
         e.en   = 4'h0;
         e.seg  = 7'h00;
         e.dp   = 1'b0;
         e.en2  = 4'hF;
         e.seg2 = 7'h7F;
         e.dp2  = 1'b1;
      end else begin
         e.en   = 4'(1 << dig);
         e.seg  = cur_seg[dig];
         e.dp   = cur_dp[dig];
         e.en2  = ~e.en;
         e.seg2 = cur_seg2[dig];
         e.dp2  = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
      push_edge();
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic tick_reset();
      @(posedge clk);
      #1;
      push_reset();
   endtask

   task automatic wait_phase(input int p);
      while (k % 16 != p) tick();
   endtask

   task automatic model_reset();
      k    = 0;
      pend = 1'b0;
      cur_dp = 4'h0;
      for (int i = 0; i < 4; i++) begin
         cur_seg[i]  = 7'h3F;
         cur_seg2[i] = 7'h40;
      end
   endtask

   // Segment tables are given most significant digit first.
   task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                          input logic [6:0] s3, input logic [6:0] s2,
                          input logic [6:0] s1, input logic [6:0] s0);
      bus1.load  = 1'b1;
      bus1.bcd   = v;
      bus1.dp_in = d;
      bus2.load  = 1'b1;
      nxt_seg[0] = s0;
      nxt_seg[1] = s1;
      nxt_seg[2] = s2;
      nxt_seg[3] = s3;
      nxt_dp     = d;
      // Inverted instance always loads A8A8: 8 -> ~7F, A -> ~00.
      nxt_seg2   = '{7'h00, 7'h7F, 7'h00, 7'h7F};
      pend       = 1'b1;
      pend_s     = k;
      tick();
      bus1.load  = 1'b0;
      bus2.load  = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus1.load     = 1'b0;
      bus1.bcd      = 16'h0000;
      bus1.dp_in    = 4'h0;
      bus1.blank_lz = 1'b0;
      bus2.load     = 1'b0;
      bus2.bcd      = 16'hA8A8;
      bus2.dp_in    = 4'h0;
      bus2.blank_lz = 1'b0;
      model_reset();
      nxt_seg  = cur_seg;
      nxt_seg2 = cur_seg2;
      nxt_dp   = 4'h0;
      pend_s   = 0;

      // Reset state, then idle frames with an all-zero display.
      tick_reset();
      tick_reset();
      reset = 1'b0;
      tick_n(34);

      // Plain digits with a decimal point on digit 2.
      do_load(16'h1234, 4'b0100, 7'h06, 7'h5B, 7'h4F, 7'h66);
      tick_n(36);

      // Leading-zero blanking; dp still shows on a blanked digit.
      bus1.blank_lz = 1'b1;
      do_load(16'h0007, 4'b1000, 7'h00, 7'h00, 7'h00, 7'h07);
      tick_n(36);
      do_load(16'h0000, 4'b0000, 7'h00, 7'h00, 7'h00, 7'h3F);
      tick_n(36);
      do_load(16'h0105, 4'b0000, 7'h00, 7'h06, 7'h3F, 7'h6D);
      tick_n(36);

      // Two mid-frame loads: last one wins, shown only from the next frame.
      wait_phase(3);
      do_load(16'h1111, 4'b0000, 7'h06, 7'h06, 7'h06, 7'h06);
      tick_n(3);
      do_load(16'h2222, 4'b0000, 7'h5B, 7'h5B, 7'h5B, 7'h5B);
      tick_n(36);

      // Load exactly on the frame boundary takes the bypass path.
      wait_phase(15);
      do_load(16'h9999, 4'b0000, 7'h6F, 7'h6F, 7'h6F, 7'h6F);
      tick_n(20);

      // Async reset mid-slot with a load still pending: pending is dropped.
      bus1.blank_lz = 1'b0;
      wait_phase(5);
      do_load(16'h5555, 4'b0000, 7'h6D, 7'h6D, 7'h6D, 7'h6D);
      #2;
      reset = 1'b1;
      // The cycle already queued as lit must now read inactive.
      void'(exp_q.pop_back());
      push_reset();
      tick_reset();
      tick_reset();
      reset = 1'b0;
      model_reset();
      tick_n(36);

      repeat (4) @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
